// File: rtl/serial_subtractor_pkg.sv
// Shared definitions for the bit-serial subtractor: FSM state encodings and
// the legal operand-width range.
package serial_subtractor_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam int WIDTH_MIN = 2;
  localparam int WIDTH_MAX = 32;

  function automatic bit width_legal(input int w);
    return (w >= WIDTH_MIN) && (w <= WIDTH_MAX);
  endfunction

endpackage

// File: rtl/serial_subtractor_if.sv
// Operation interface of the serial subtractor: start/ready/done handshake,
// operands in, registered result out.
interface serial_subtractor_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             ready;
  logic             done;
  logic [WIDTH-1:0] diff;
  logic             borrow;

  modport master (output start, a, b, input ready, done, diff, borrow);
  modport slave  (input start, a, b, output ready, done, diff, borrow);
endinterface

// File: rtl/serial_subtractor_full_subtractor.sv
// One-bit full subtractor: diff = a - b - bin, bout set when the step needs
// to borrow from the next bit.
module full_subtractor (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic diff,
  output logic bout
);
  assign diff = a ^ b ^ bin;
  assign bout = (~a & b) | (~(a ^ b) & bin);
endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial WIDTH-bit subtractor: one bit per clock, LSB first, with a
// single borrow flop. Result and borrow-out are registered on entry to DONE.
module serial_subtractor
  import serial_subtractor_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input logic clk,
  input logic rst,
  serial_subtractor_if.slave bus
);

  localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  state_t           state_reg, state_next;
  logic [WIDTH-1:0] a_sr_reg, b_sr_reg, res_sr_reg, diff_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic             borrow_ff_reg, borrow_reg;
  logic             bit_diff, bit_bout, last_bit;

  full_subtractor u_full_subtractor (
    .a    (a_sr_reg[0]),
    .b    (b_sr_reg[0]),
    .bin  (borrow_ff_reg),
    .diff (bit_diff),
    .bout (bit_bout)
  );

  assign last_bit   = (cnt_reg == CNT_LAST);
  assign bus.diff   = diff_reg;
  assign bus.borrow = borrow_reg;

  always_comb begin
    state_next = state_reg;
    bus.ready  = 1'b0;
    bus.done   = 1'b0;
    case (state_reg)
      S_IDLE: begin
        bus.ready = 1'b1;
        if (bus.start) state_next = S_RUN;
      end
      S_RUN: begin
        if (last_bit) state_next = S_DONE;
      end
      S_DONE: begin
        bus.done   = 1'b1;
        state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= S_IDLE;
      a_sr_reg      <= '0;
      b_sr_reg      <= '0;
      res_sr_reg    <= '0;
      diff_reg      <= '0;
      cnt_reg       <= '0;
      borrow_ff_reg <= 1'b0;
      borrow_reg    <= 1'b0;
    end else begin
      state_reg <= state_next;
      case (state_reg)
        S_IDLE: begin
          if (bus.start) begin
            a_sr_reg      <= bus.a;
            b_sr_reg      <= bus.b;
            res_sr_reg    <= '0;
            cnt_reg       <= '0;
            borrow_ff_reg <= 1'b0;
          end
        end
        S_RUN: begin
          res_sr_reg    <= {bit_diff, res_sr_reg[WIDTH-1:1]};
          a_sr_reg      <= {1'b0, a_sr_reg[WIDTH-1:1]};
          b_sr_reg      <= {1'b0, b_sr_reg[WIDTH-1:1]};
          borrow_ff_reg <= bit_bout;
          cnt_reg       <= cnt_reg + 1'b1;
          // The MSB step publishes the result including the bit computed now.
          if (last_bit) begin
            diff_reg   <= {bit_diff, res_sr_reg[WIDTH-1:1]};
            borrow_reg <= bit_bout;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_subtractor.sv
// Scoreboard bench for serial_subtractor (WIDTH=8): stimulus pushes expected
// results at accept time; a negedge monitor checks every done pulse.
module tb_serial_subtractor;
  localparam int W = 8;

  typedef struct {
    logic [W-1:0] d;
    logic         bo;
    int           cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   errors = 0;
  int   checks = 0;
  int   accept_cnt = 0;
  int   done_cnt = 0;
  bit   mon_en = 1'b0;
  logic [W-1:0] hold_diff = '0;
  logic         hold_borrow = 1'b0;
  exp_t exp_q[$];

  serial_subtractor_if #(.WIDTH(W)) bus ();

  serial_subtractor #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: scores every done pulse and checks diff/borrow hold otherwise.
  always @(negedge clk) begin
    if (mon_en) begin
      if (bus.done === 1'b1) begin
        done_cnt++;
        if (exp_q.size() == 0) begin
          chk("unexpected_done", 1, 0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("diff", bus.diff, e.d);
          chk("borrow", bus.borrow, e.bo);
          chk("done_latency", cyc, e.cyc);
          hold_diff   = e.d;
          hold_borrow = e.bo;
          $display("op done: diff=%0d borrow=%0d cycle=%0d", bus.diff, bus.borrow, cyc);
        end
      end else begin
        chk("diff_hold", bus.diff, hold_diff);
        chk("borrow_hold", bus.borrow, hold_borrow);
      end
    end
  end

  task automatic push_exp(input logic [W-1:0] x, input logic [W-1:0] y);
    exp_t e;
    e.d   = x - y;
    e.bo  = (x < y);
    e.cyc = cyc + W;
    exp_q.push_back(e);
    accept_cnt++;
  endtask

  task automatic issue(input logic [W-1:0] x, input logic [W-1:0] y);
    int n = 0;
    @(negedge clk);
    while (bus.ready !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (bus.ready !== 1'b1) chk("ready_timeout", 0, 1);
    bus.start = 1'b1;
    bus.a     = x;
    bus.b     = y;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    push_exp(x, y);
    chk("ready_drop", bus.ready, 0);
  endtask

  task automatic wait_done();
    int n = 0;
    @(negedge clk);
    while (bus.done !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (bus.done !== 1'b1) chk("done_timeout", 0, 1);
    @(negedge clk);
    chk("ready_after_done", bus.ready, 1);
  endtask

  task automatic run_op(input logic [W-1:0] x, input logic [W-1:0] y);
    issue(x, y);
    wait_done();
  endtask

  initial begin
    int n;
    int acc1;
    logic [W-1:0] vx [5] = '{8'd100, 8'd37, 8'd0, 8'd255, 8'd0};
    logic [W-1:0] vy [5] = '{8'd37, 8'd100, 8'd1, 8'd255, 8'd0};
    bus.start = 1'b0;
    bus.a     = '0;
    bus.b     = '0;

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_ready", bus.ready, 1);
    chk("rst_done", bus.done, 0);
    chk("rst_diff", bus.diff, 0);
    chk("rst_borrow", bus.borrow, 0);
    mon_en = 1'b1;

    // Directed vectors.
    for (int i = 0; i < 5; i++) run_op(vx[i], vy[i]);

    // Start pulses and operand changes during RUN are ignored.
    issue(8'd50, 8'd20);
    bus.start = 1'b1; bus.a = 8'd9; bus.b = 8'd9;
    @(posedge clk); #1 bus.a = 8'd77; bus.b = 8'd201;
    @(posedge clk); #1 bus.start = 1'b0; bus.a = 8'd3;
    wait_done();
    repeat (12) @(negedge clk);
    chk("ignored_start_done_cnt", done_cnt, accept_cnt);

    // Abort by reset in the middle of RUN.
    issue(8'd200, 8'd1);
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    exp_q.delete();
    accept_cnt--;
    hold_diff = '0;
    hold_borrow = 1'b0;
    @(negedge clk);
    chk("abort_ready", bus.ready, 1);
    chk("abort_diff", bus.diff, 0);
    chk("abort_borrow", bus.borrow, 0);
    repeat (12) @(negedge clk);
    run_op(8'd7, 8'd3);

    // Reset and start on the same edge: reset wins, block stays idle.
    @(negedge clk);
    rst = 1'b1; bus.start = 1'b1;
    @(posedge clk); #1 rst = 1'b0; bus.start = 1'b0;
    hold_diff = '0;
    hold_borrow = 1'b0;
    @(negedge clk);
    chk("rst_over_start_ready", bus.ready, 1);

    // start held high: back-to-back accepts every WIDTH+2 cycles.
    @(negedge clk);
    bus.start = 1'b1; bus.a = 8'd10; bus.b = 8'd3;
    @(posedge clk); #1;
    push_exp(8'd10, 8'd3);
    acc1 = cyc;
    bus.a = 8'd3; bus.b = 8'd10;
    n = 0;
    @(negedge clk);
    while (bus.ready !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk); #1;
    push_exp(8'd3, 8'd10);
    bus.start = 1'b0;
    chk("held_start_spacing", cyc - acc1, W + 2);
    wait_done();

    // Random sweep against the arithmetic reference.
    for (int i = 0; i < 200; i++) begin
      issue(W'($urandom_range(0, 255)), W'($urandom_range(0, 255)));
    end
    n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    repeat (3) @(negedge clk);
    chk("queue_drained", exp_q.size(), 0);
    chk("done_vs_accept", done_cnt, accept_cnt);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
